// File: rtl/pixel_write_queue_pkg.sv
// Shared screen/colour defines and common types for the pixel write queue.
// The defines are also used by the brick/ball/paddle drawers.
`ifndef PIXEL_SCREEN_DEFINES
`define PIXEL_SCREEN_DEFINES
`define SCREENX 160
`define SCREENY 120
`define COLOR_W 3
`define BRICKX 16
`define BRICKY 8
`endif

package pixel_write_queue_pkg;

    localparam int COLOR_W = `COLOR_W;
    localparam int COORD_W = 10;

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_VALID = 1'b1;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO holding pre-computed {address, colour} pixel entries.
// DEPTH must be a power of two so the pointers wrap naturally.
module pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 18
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/pixel_write_queue.sv
// Buffers drawer pixel writes and issues them to the framebuffer write port.
// Define PIXEL_CLIP_EN to drop off-screen pixels at the input.
module pixel_write_queue
    import pixel_write_queue_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 15
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    writeEn,
    input  logic [9:0]              x_in,
    input  logic [9:0]              y_in,
    input  logic [2:0]              color_in,
    input  logic                    mem_busy,
    output logic                    mem_wren,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [2:0]              mem_data,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow,
    output logic                    idle
);

    localparam int EW = ADDR_W + COLOR_W;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        data_q, data_d;
    logic              ovf_q, ovf_d;

    logic [19:0]       y_ext;
    logic [ADDR_W-1:0] in_addr;
    logic              clip;
    logic              push, pop;
    logic              fifo_full, fifo_empty;
    logic [EW-1:0]     head;

`ifdef PIXEL_CLIP_EN
    assign clip = (x_in >= 10'(`SCREENX)) || (y_in >= 10'(`SCREENY));
`else
    assign clip = 1'b0;
`endif

    // y*160 + x as two shifts; out-of-range results wrap at ADDR_W.
    always_comb begin
        y_ext   = {10'b0, y_in};
        in_addr = ADDR_W'(y_ext << 7) + ADDR_W'(y_ext << 5) + ADDR_W'(x_in);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_VALID;
                end
            end
            default: begin
                if (!mem_busy) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
            end
        endcase
        if (pop) begin
            {addr_d, data_d} = head;
        end
    end

    // A full FIFO still accepts when the head leaves in the same cycle.
    always_comb begin
        push  = writeEn && !clip && (!fifo_full || pop);
        ovf_d = ovf_q || (writeEn && !clip && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_EMPTY;
            addr_q  <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    pixel_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (push),
        .pop     (pop),
        .wr_data ({in_addr, color_in}),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign mem_wren = (state_q == S_VALID);
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign overflow = ovf_q;
    assign idle     = fifo_empty && (state_q == S_EMPTY);

endmodule

// File: tb/tb_pixel_write_queue.sv
// Scoreboard bench for pixel_write_queue: directed pixel streams,
// expected writes queued at issue and checked by a write monitor.
module tb_pixel_write_queue;

    logic        clk;
    logic        resetn;
    logic        writeEn;
    logic [9:0]  x_in;
    logic [9:0]  y_in;
    logic [2:0]  color_in;
    logic        mem_busy;
    logic        mem_wren;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic        idle;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int wr_cnt = 0;
    int max_cnt = 0;
    bit track  = 0;
    logic [17:0] exp_q [$];
    int wr_cyc [$];

    pixel_write_queue #(.DEPTH(16), .ADDR_W(15)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .writeEn    (writeEn),
        .x_in       (x_in),
        .y_in       (y_in),
        .color_in   (color_in),
        .mem_busy   (mem_busy),
        .mem_wren   (mem_wren),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic expect_px(input int x, input int y, input int c);
        logic [14:0] a;
        a = 15'(y * 160 + x);
        exp_q.push_back({a, 3'(c)});
    endtask

    // Write monitor: a write completes on any cycle with mem_wren and !mem_busy.
    always @(negedge clk) begin
        logic [17:0] e;
        if (resetn && track && fifo_count > 5'(max_cnt)) max_cnt = int'(fifo_count);
        if (resetn && mem_wren && !mem_busy) begin
            wr_cnt++;
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0d required none", mem_addr, mem_data);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(mem_addr), 32'(e[17:3]));
                chk("write_data", 32'(mem_data), 32'(e[2:0]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int y, input int c);
        writeEn  = 1'b1;
        x_in     = 10'(x);
        y_in     = 10'(y);
        color_in = 3'(c);
        step(1);
        writeEn  = 1'b0;
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        int n = 0;
        while (wr_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        chk(name, 32'(wr_cnt >= target), 32'd1);
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        writeEn  = 1'b0;
        mem_busy = 1'b0;
        exp_q.delete();
        step(2);
        resetn = 1'b1;
    endtask

    initial begin
        int base;
        resetn   = 1'b0;
        writeEn  = 1'b0;
        x_in     = '0;
        y_in     = '0;
        color_in = '0;
        mem_busy = 1'b0;
        step(2);
        chk("rst_wren", 32'(mem_wren), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_data", 32'(mem_data), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_idle", 32'(idle), 1);
        resetn = 1'b1;
        step(1);

        // Single pixel latency.
        expect_px(5, 2, 5);
        drive(5, 2, 5);
        @(negedge clk);
        chk("lat_cycle1_wren", 32'(mem_wren), 0);
        @(negedge clk);
        chk("lat_cycle2_wren", 32'(mem_wren), 1);
        chk("lat_addr", 32'(mem_addr), 325);
        chk("lat_data", 32'(mem_data), 5);
        @(negedge clk);
        chk("lat_cycle3_idle", 32'(idle), 1);
        step(1);

        // Brick burst, no back-pressure.
        wr_cyc.delete();
        max_cnt = 0;
        track   = 1;
        base    = wr_cnt;
        for (int i = 0; i < 20; i++) begin
            expect_px(10 + i, 3, i % 8);
            writeEn  = 1'b1;
            x_in     = 10'(10 + i);
            y_in     = 10'd3;
            color_in = 3'(i % 8);
            step(1);
        end
        writeEn = 1'b0;
        wait_writes(base + 20, 40, "burst_done");
        track = 0;
        chk("burst_writes", 32'(wr_cyc.size()), 20);
        if (wr_cyc.size() >= 20)
            chk("burst_consecutive", 32'(wr_cyc[19] - wr_cyc[0]), 19);
        chk("burst_max_count", 32'(max_cnt), 1);
        chk("burst_overflow", 32'(overflow), 0);

        // Back-pressure: 16 queued + 1 held, 3 dropped.
        step(2);
        mem_busy = 1'b1;
        base = wr_cnt;
        for (int i = 0; i < 20; i++) begin
            if (i < 17) expect_px(i, 50, (i + 3) % 8);
            writeEn  = 1'b1;
            x_in     = 10'(i);
            y_in     = 10'd50;
            color_in = 3'((i + 3) % 8);
            step(1);
        end
        writeEn = 1'b0;
        step(10);
        chk("bp_count", 32'(fifo_count), 16);
        chk("bp_overflow", 32'(overflow), 1);
        chk("bp_wren_held", 32'(mem_wren), 1);
        chk("bp_idle", 32'(idle), 0);
        mem_busy = 1'b0;
        wait_writes(base + 17, 40, "bp_drain");
        step(3);
        chk("bp_left", 32'(exp_q.size()), 0);
        chk("bp_idle_after", 32'(idle), 1);
        chk("bp_overflow_sticky", 32'(overflow), 1);

        // Push and pop in the same cycle while full.
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            expect_px(i, 7, i % 8);
            writeEn  = 1'b1;
            x_in     = 10'(i);
            y_in     = 10'd7;
            color_in = 3'(i % 8);
            step(1);
        end
        writeEn = 1'b0;
        step(1);
        chk("full_count", 32'(fifo_count), 16);
        chk("full_overflow", 32'(overflow), 0);
        base = wr_cnt;
        expect_px(99, 9, 6);
        mem_busy = 1'b0;
        drive(99, 9, 6);
        mem_busy = 1'b1;
        chk("pp_count", 32'(fifo_count), 16);
        chk("pp_overflow", 32'(overflow), 0);
        chk("pp_one_write", 32'(wr_cnt - base), 1);
        mem_busy = 1'b0;
        wait_writes(base + 18, 50, "pp_drain");
        step(2);
        chk("pp_left", 32'(exp_q.size()), 0);

        // Off-screen coordinates.
        base = wr_cnt;
`ifndef PIXEL_CLIP_EN
        expect_px(160, 0, 1);
        expect_px(0, 120, 2);
`endif
        drive(160, 0, 1);
        step(1);
        drive(0, 120, 2);
        step(8);
`ifdef PIXEL_CLIP_EN
        chk("clip_writes", 32'(wr_cnt - base), 0);
`else
        chk("wrap_writes", 32'(wr_cnt - base), 2);
`endif
        chk("clip_overflow", 32'(overflow), 0);
        chk("clip_left", 32'(exp_q.size()), 0);
        chk("clip_idle", 32'(idle), 1);

        // Reset while a write is pending with 5 queued.
        mem_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            writeEn  = 1'b1;
            x_in     = 10'(20 + i);
            y_in     = 10'd11;
            color_in = 3'(i);
            step(1);
        end
        writeEn = 1'b0;
        step(1);
        chk("mid_count", 32'(fifo_count), 5);
        chk("mid_wren", 32'(mem_wren), 1);
        resetn = 1'b0;
        step(1);
        chk("mrst_wren", 32'(mem_wren), 0);
        chk("mrst_count", 32'(fifo_count), 0);
        chk("mrst_overflow", 32'(overflow), 0);
        chk("mrst_idle", 32'(idle), 1);
        chk("mrst_addr", 32'(mem_addr), 0);
        resetn   = 1'b1;
        mem_busy = 1'b0;
        base     = wr_cnt;
        step(10);
        chk("mrst_no_stale", 32'(wr_cnt - base), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
